// File: rtl/bitty_core_pkg.sv
// bitty_core shared types: ALU ops, formats, FSM states, decoded instruction.
// Instruction field positions and a shift-amount width helper.
package bitty_core_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_CMP = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    FMT_REG  = 2'b00,
    FMT_IMM  = 2'b01,
    FMT_BAD2 = 2'b10,
    FMT_BAD3 = 2'b11
  } fmt_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_WB
  } state_e;

  localparam int RX_LSB  = 13;
  localparam int RY_LSB  = 10;
  localparam int IMM_LSB = 5;
  localparam int OP_LSB  = 2;
  localparam int FMT_LSB = 0;

  typedef struct packed {
    logic [2:0] rx;
    logic [2:0] ry;
    logic [7:0] imm;
    op_e        op;
    fmt_e       fmt;
  } instr_t;

  function automatic int shamt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  function automatic instr_t decode(input logic [15:0] i);
    instr_t d;
    d.rx  = i[RX_LSB +: 3];
    d.ry  = i[RY_LSB +: 3];
    d.imm = i[IMM_LSB +: 8];
    d.op  = op_e'(i[OP_LSB +: 3]);
    d.fmt = fmt_e'(i[FMT_LSB +: 2]);
    return d;
  endfunction

endpackage

// File: rtl/bitty_alu.sv
// bitty_alu: combinational ALU for bitty_core.
// ADD/SUB/CMP use a DATA_W+1 bit sum; logic and shifts clear carry.
module bitty_alu
  import bitty_core_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  op_e               op,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  localparam int SW = shamt_w(DATA_W);

  logic [DATA_W:0] sum;
  logic [SW-1:0]   sh;

  assign sh = b[SW-1:0];

  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    unique case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      // carry doubles as borrow: set when a < b unsigned
      OP_SUB, OP_CMP: begin
        sum    = {1'b0, a} - {1'b0, b};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: result = a << sh;
      OP_SHR: result = a >> sh;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/bitty_core.sv
// bitty_core: multi-cycle register machine, IDLE/LOAD/EXEC/WB per instruction.
// Optional BITTY_CORE_DBG_EN adds a combinational register-file read port.
module bitty_core
  import bitty_core_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [15:0]       d_instr,
  output logic [DATA_W-1:0] d_out,
  output logic              done,
  output logic [1:0]        flags,
  output logic              err
`ifdef BITTY_CORE_DBG_EN
  ,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`endif
);

  if (NUM_REGS != 8) begin : g_regs_chk
    $error("bitty_core: NUM_REGS must be 8");
  end

  if (DATA_W < 8 || DATA_W > 64) begin : g_width_chk
    $error("bitty_core: DATA_W must be 8..64");
  end

  state_e state_q, state_d;

  logic [15:0]       instr_q;
  logic [DATA_W-1:0] s_q;
  logic [DATA_W-1:0] c_q;
  logic [1:0]        flags_q;
  logic              err_q;
  logic [DATA_W-1:0] rf [NUM_REGS];

  instr_t            di;
  logic              legal;
  logic              writes;
  logic              cap;
  logic [DATA_W-1:0] b_val;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_z;

  assign di     = decode(instr_q);
  assign legal  = (di.fmt == FMT_REG) || (di.fmt == FMT_IMM);
  assign writes = legal && (di.op != OP_CMP);
  assign b_val  = (di.fmt == FMT_IMM) ? DATA_W'(di.imm) : rf[di.ry];

  bitty_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a      (s_q),
    .b      (b_val),
    .op     (di.op),
    .result (alu_res),
    .carry  (alu_c),
    .zero   (alu_z)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // WB accepts a new instruction directly for 3-cycle issue
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          cap     = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB: begin
        done = 1'b1;
        if (run) begin
          cap     = 1'b1;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= '0;
      s_q     <= '0;
      c_q     <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (cap) instr_q <= d_instr;
      if (state_q == S_LOAD) s_q <= rf[di.rx];
      if (state_q == S_EXEC) begin
        if (legal) flags_q <= {alu_c, alu_z};
        else       err_q   <= 1'b1;
        if (writes) c_q <= alu_res;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (state_q == S_WB && writes) begin
      rf[di.rx] <= c_q;
    end
  end

  assign d_out = c_q;
  assign flags = flags_q;
  assign err   = err_q;

`ifdef BITTY_CORE_DBG_EN
  assign dbg_data = rf[dbg_addr];
`endif

endmodule

// File: tb/tb_bitty_core.sv
// tb_bitty_core: directed and randomized checks of bitty_core
// against an arithmetic reference model of the instruction set.
module tb_bitty_core;

  localparam int DW = 16;
  localparam longint MASK = (64'd1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          run = 1'b0;
  logic [15:0]   d_instr = '0;
  logic [DW-1:0] d_out;
  logic          done;
  logic [1:0]    flags;
  logic          err;
`ifdef BITTY_CORE_DBG_EN
  logic [2:0]    dbg_addr = '0;
  logic [DW-1:0] dbg_data;
`endif

  int checks = 0;
  int passed = 0;

  longint m_r [8];
  longint m_c;
  logic [1:0] m_flags;
  logic m_err;

  bitty_core #(
    .DATA_W   (DW),
    .NUM_REGS (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .d_instr  (d_instr),
    .d_out    (d_out),
    .done     (done),
    .flags    (flags),
    .err      (err)
`ifdef BITTY_CORE_DBG_EN
    ,
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] enc_i(input int rx, input int op, input int imm);
    logic [15:0] w;
    w = '0;
    w[15:13] = rx[2:0];
    w[12:5]  = imm[7:0];
    w[4:2]   = op[2:0];
    w[1:0]   = 2'b01;
    return w;
  endfunction

  function automatic logic [15:0] enc_r(input int rx, input int ry, input int op);
    logic [15:0] w;
    w = '0;
    w[15:13] = rx[2:0];
    w[12:10] = ry[2:0];
    w[4:2]   = op[2:0];
    w[1:0]   = 2'b00;
    return w;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 0;
    m_c = 0;
    m_flags = 2'b00;
    m_err = 1'b0;
  endfunction

  function automatic void model(input logic [15:0] ins);
    int rx, ry, op, fmt;
    longint a, b, r;
    logic cy;
    rx = int'(ins[15:13]);
    ry = int'(ins[12:10]);
    op = int'(ins[4:2]);
    fmt = int'(ins[1:0]);
    if (fmt > 1) begin
      m_err = 1'b1;
      return;
    end
    a = m_r[rx];
    b = (fmt == 0) ? m_r[ry] : longint'(ins[12:5]);
    cy = 1'b0;
    r = 0;
    case (op)
      0: begin r = a + b; cy = (r > MASK); end
      1, 7: begin r = a - b; cy = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a << (b % DW);
      default: r = a >> (b % DW);
    endcase
    r = r & MASK;
    m_flags = {cy, r == 0};
    if (op != 7) begin
      m_c = r;
      m_r[rx] = r;
    end
  endfunction

  task automatic run_instr(input logic [15:0] ins, output int lat);
    @(negedge clk);
    run = 1'b1;
    d_instr = ins;
    @(posedge clk);
    #1 run = 1'b0;
    d_instr = 16'($urandom);
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    model(ins);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    checks++; if (d_out !== '0) $display("FAIL rst_dout got %h exp 0", d_out); else passed++;
    checks++; if ({done, err, flags} !== 4'b0) $display("FAIL rst_status got %b exp 0000", {done, err, flags}); else passed++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL rst_idle_done got %b exp 0", done); else passed++;
  endtask

  task automatic test_add_imm();
    int lat;
    run_instr(enc_i(0, 0, 8'h05), lat);
    checks++; if (lat !== 3) $display("FAIL add_latency got %0d exp 3", lat); else passed++;
    checks++; if (d_out !== 16'h0005) $display("FAIL add_dout got %h exp 0005", d_out); else passed++;
    checks++; if (flags !== 2'b00) $display("FAIL add_flags got %b exp 00", flags); else passed++;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL add_done_width got %b exp 0", done); else passed++;
  endtask

  task automatic test_sub_borrow();
    int lat;
    run_instr(enc_i(1, 0, 3), lat);
    run_instr(enc_i(1, 7, 4), lat);
    checks++; if (flags !== 2'b10) $display("FAIL cmp_flags got %b exp 10", flags); else passed++;
    checks++; if (d_out !== 16'h0003) $display("FAIL cmp_keeps_c got %h exp 0003", d_out); else passed++;
`ifdef BITTY_CORE_DBG_EN
    dbg_addr = 3'd1;
    #1;
    checks++; if (dbg_data !== 16'h0003) $display("FAIL cmp_dbg_r1 got %h exp 0003", dbg_data); else passed++;
`endif
    run_instr(enc_i(1, 0, 0), lat);
    checks++; if (d_out !== 16'h0003) $display("FAIL cmp_r1_kept got %h exp 0003", d_out); else passed++;
    run_instr(enc_i(1, 1, 3), lat);
    checks++; if (d_out !== 16'h0000) $display("FAIL sub_dout got %h exp 0000", d_out); else passed++;
    checks++; if (flags !== 2'b01) $display("FAIL sub_flags got %b exp 01", flags); else passed++;
  endtask

  task automatic test_shifts();
    int lat;
    run_instr(enc_i(2, 0, 8'hF0), lat);
    run_instr(enc_i(3, 0, 4), lat);
    run_instr(enc_r(2, 3, 5), lat);
    checks++; if (d_out !== 16'h0F00) $display("FAIL shl_dout got %h exp 0f00", d_out); else passed++;
    checks++; if (flags !== 2'b00) $display("FAIL shl_flags got %b exp 00", flags); else passed++;
    run_instr(enc_r(2, 3, 6), lat);
    checks++; if (d_out !== 16'h00F0) $display("FAIL shr_dout got %h exp 00f0", d_out); else passed++;
    run_instr(enc_i(4, 1, 1), lat);
    checks++; if (d_out !== 16'hFFFF) $display("FAIL wrap_sub_dout got %h exp ffff", d_out); else passed++;
    checks++; if (flags !== 2'b10) $display("FAIL wrap_sub_flags got %b exp 10", flags); else passed++;
    run_instr(enc_i(4, 0, 8'hFF), lat);
    checks++; if (d_out !== 16'h00FE) $display("FAIL wrap_add_dout got %h exp 00fe", d_out); else passed++;
    checks++; if (flags !== 2'b10) $display("FAIL wrap_add_flags got %b exp 10", flags); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat, n, gap, guard;
    logic [15:0] ins;
    run_instr(enc_r(0, 0, 1), lat);
    checks++; if (d_out !== 16'h0000) $display("FAIL b2b_clear got %h exp 0000", d_out); else passed++;
    ins = enc_i(0, 0, 1);
    n = 0;
    gap = 0;
    guard = 0;
    @(negedge clk);
    run = 1'b1;
    d_instr = ins;
    while (n < 4 && guard < 60) begin
      @(negedge clk);
      guard++;
      gap++;
      if (done) begin
        model(ins);
        checks++; if (gap !== 3) $display("FAIL b2b_gap got %0d exp 3", gap); else passed++;
        checks++; if (d_out !== 16'(n + 1)) $display("FAIL b2b_dout got %h exp %h", d_out, 16'(n + 1)); else passed++;
        n++;
        gap = 0;
        if (n < 4) d_instr = ins;
        else run = 1'b0;
      end else begin
        d_instr = 16'($urandom);
      end
    end
    run = 1'b0;
    checks++; if (n !== 4) $display("FAIL b2b_count got %0d exp 4", n); else passed++;
  endtask

  task automatic test_illegal();
    int lat;
    logic [15:0] bad;
    longint c0;
    logic [1:0] f0;
    c0 = m_c;
    f0 = m_flags;
    bad = enc_i(2, 0, 8'h11);
    bad[1:0] = 2'b10;
    run_instr(bad, lat);
    checks++; if (lat !== 3) $display("FAIL ill_done got %0d exp 3", lat); else passed++;
    checks++; if (err !== 1'b1) $display("FAIL ill_err got %b exp 1", err); else passed++;
    checks++; if (d_out !== 16'(c0)) $display("FAIL ill_c got %h exp %h", d_out, 16'(c0)); else passed++;
    checks++; if (flags !== f0) $display("FAIL ill_flags got %b exp %b", flags, f0); else passed++;
    run_instr(enc_i(2, 0, 0), lat);
    checks++; if (d_out !== 16'h00F0) $display("FAIL ill_r2_kept got %h exp 00f0", d_out); else passed++;
    checks++; if (err !== 1'b1) $display("FAIL ill_err_sticky got %b exp 1", err); else passed++;
  endtask

  task automatic test_random();
    int n, gap, guard;
    logic [15:0] ins;
    ins = '0;
    n = 0;
    gap = 0;
    guard = 0;
    @(negedge clk);
    run = 1'b1;
    ins = 16'($urandom);
    if ($urandom_range(0, 9) != 0) ins[1] = 1'b0;
    d_instr = ins;
    while (n < 40 && guard < 400) begin
      @(negedge clk);
      guard++;
      gap++;
      if (done) begin
        model(ins);
        checks++;
        if (gap !== 3 || d_out !== 16'(m_c) || flags !== m_flags || err !== m_err)
          $display("FAIL rand_%0d ins %h got gap %0d d %h f %b e %b exp gap 3 d %h f %b e %b",
                   n, ins, gap, d_out, flags, err, 16'(m_c), m_flags, m_err);
        else passed++;
        n++;
        gap = 0;
        ins = 16'($urandom);
        if ($urandom_range(0, 9) != 0) ins[1] = 1'b0;
        if (n < 40) d_instr = ins;
        else run = 1'b0;
      end else begin
        d_instr = 16'($urandom);
      end
    end
    run = 1'b0;
    checks++; if (n !== 40) $display("FAIL rand_count got %0d exp 40", n); else passed++;
  endtask

  task automatic test_reset_mid_op();
    int lat, pulses;
    @(negedge clk);
    run = 1'b1;
    d_instr = enc_i(5, 0, 8'h33);
    @(posedge clk);
    #1 run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    checks++; if (d_out !== '0) $display("FAIL mid_rst_dout got %h exp 0", d_out); else passed++;
    checks++; if ({done, err, flags} !== 4'b0) $display("FAIL mid_rst_status got %b exp 0000", {done, err, flags}); else passed++;
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++; if (pulses !== 0) $display("FAIL mid_rst_idle got %0d exp 0", pulses); else passed++;
    run_instr(enc_i(5, 0, 0), lat);
    checks++; if (d_out !== 16'h0000) $display("FAIL mid_rst_no_wb got %h exp 0000", d_out); else passed++;
    checks++; if (flags !== 2'b01) $display("FAIL mid_rst_flags got %b exp 01", flags); else passed++;
    run_instr(enc_i(0, 0, 0), lat);
    checks++; if (d_out !== 16'h0000) $display("FAIL mid_rst_r0 got %h exp 0000", d_out); else passed++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_add_imm();
    test_sub_borrow();
    test_shifts();
    test_back_to_back();
    test_illegal();
    test_random();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
